// File: rtl/pc_pkg.sv
// Shared types for the program counter with branch/call support.
// Holds the priority-resolved action encoding and the stack counter width.
package pc_pkg;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_CLR  = 3'd1,
    ACT_RET  = 3'd2,
    ACT_CALL = 3'd3,
    ACT_JMP  = 3'd4,
    ACT_BR   = 3'd5,
    ACT_UP   = 3'd6
  } pc_act_t;

  localparam int DEF_DEPTH = 4;
  localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

  // The counter must hold DEPTH itself, hence DEPTH+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_branch_stack_ret_stack.sv
// LIFO of return addresses; only the occupancy count is reset, entry contents
// are left as they are and treated as don't-care.
module ret_stack
  import pc_pkg::*;
#(
  parameter int N     = 7,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [N-1:0] i_push_data,
  output logic [N-1:0] o_top_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_mem [DEPTH];
  logic [CW-1:0] w_top_cnt;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_top_cnt  = r_cnt - CW'(1);
  assign w_wr_idx   = r_cnt[IW-1:0];
  assign w_rd_idx   = w_top_cnt[IW-1:0];
  assign o_full     = (r_cnt == CW'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_top_data = o_empty ? '0 : r_mem[w_rd_idx];

  // occupancy count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= w_top_cnt;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // entry storage, written on push only
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_branch_stack.sv
// Program counter with absolute jump, relative branch, call/return stack and
// a wrap-or-halt end-of-memory policy.
module pc_branch_stack
  import pc_pkg::*;
#(
  parameter int N     = 7,
  parameter int DEPTH = 4,
  parameter int WRAP  = 1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Clr,
  input  logic         Up,
  input  logic         Jmp,
  input  logic         Br,
  input  logic         Call,
  input  logic         Ret,
  input  logic [N-1:0] Target,
  input  logic [N-1:0] Offset,
  output logic [N-1:0] Addr,
  output logic         Halted,
  output logic         StackFull,
  output logic         StackEmpty,
  output logic         Fault
);

  pc_act_t      w_act;
  logic [N-1:0] r_addr;
  logic         r_halted;
  logic         r_fault;
  logic [N-1:0] w_addr_nxt;
  logic         w_halted_nxt;
  logic         w_fault_nxt;
  logic [N-1:0] w_top;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  // one action per cycle; Up and Br are dropped while halted
  always_comb begin
    w_act = ACT_NONE;
    if (Clr) begin
      w_act = ACT_CLR;
    end else if (Ret) begin
      w_act = ACT_RET;
    end else if (Call) begin
      w_act = ACT_CALL;
    end else if (Jmp) begin
      w_act = ACT_JMP;
    end else if (Br && !r_halted) begin
      w_act = ACT_BR;
    end else if (Up && !r_halted) begin
      w_act = ACT_UP;
    end else begin
      w_act = ACT_NONE;
    end
  end

  assign w_push = (w_act == ACT_CALL) && !w_full;
  assign w_pop  = (w_act == ACT_RET) && !w_empty;

  ret_stack #(.N(N), .DEPTH(DEPTH)) u_stack (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_clr       (Clr),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (r_addr + N'(1)),
    .o_top_data  (w_top),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // next PC, halt and fault; a redirect that moves the PC releases a halt
  always_comb begin
    w_addr_nxt   = r_addr;
    w_halted_nxt = r_halted;
    w_fault_nxt  = r_fault;
    case (w_act)
      ACT_CLR: begin
        w_addr_nxt   = '0;
        w_halted_nxt = 1'b0;
        w_fault_nxt  = 1'b0;
      end
      ACT_RET: begin
        if (w_empty) begin
          w_fault_nxt = 1'b1;
        end else begin
          w_addr_nxt   = w_top;
          w_halted_nxt = r_halted && (w_top == r_addr);
        end
      end
      ACT_CALL: begin
        if (w_full) begin
          w_fault_nxt = 1'b1;
        end else begin
          w_addr_nxt   = Target;
          w_halted_nxt = r_halted && (Target == r_addr);
        end
      end
      ACT_JMP: begin
        w_addr_nxt   = Target;
        w_halted_nxt = r_halted && (Target == r_addr);
      end
      ACT_BR: w_addr_nxt = r_addr + Offset;
      ACT_UP: begin
        if (r_addr != '1) begin
          w_addr_nxt = r_addr + N'(1);
        end else if (WRAP != 0) begin
          w_addr_nxt = '0;
        end else begin
          w_halted_nxt = 1'b1;
        end
      end
      default: w_addr_nxt = r_addr;
    endcase
  end

  // architectural state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr   <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_addr   <= w_addr_nxt;
      r_halted <= w_halted_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  assign Addr       = r_addr;
  assign Halted     = r_halted;
  assign Fault      = r_fault;
  assign StackFull  = w_full;
  assign StackEmpty = w_empty;

endmodule

// File: tb/tb_pc_branch_stack.sv
// Scoreboard bench: the driver queues hand-computed expectations, the monitor
// compares them on the falling edge after each update.
module tb_pc_branch_stack;

  localparam logic [5:0] R_NONE = 6'b000000;
  localparam logic [5:0] R_UP   = 6'b000001;
  localparam logic [5:0] R_BR   = 6'b000010;
  localparam logic [5:0] R_JMP  = 6'b000100;
  localparam logic [5:0] R_CALL = 6'b001000;
  localparam logic [5:0] R_RET  = 6'b010000;
  localparam logic [5:0] R_CLR  = 6'b100000;

  typedef struct packed {
    logic       dut;
    logic [6:0] addr;
    logic       halted;
    logic       fault;
    logic       full;
    logic       empty;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       sel;
  logic [5:0] req;
  logic [6:0] target;
  logic [6:0] offset;
  logic [5:0] req_a;
  logic [5:0] req_b;

  logic [6:0] a_addr, b_addr;
  logic a_halted, a_full, a_empty, a_fault;
  logic b_halted, b_full, b_empty, b_fault;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;
  int    checks = 0;
  int    errors = 0;

  always #5 Clk = ~Clk;

  assign req_a = sel ? 6'b000000 : req;
  assign req_b = sel ? req : 6'b000000;

  pc_branch_stack #(.N(7), .DEPTH(4), .WRAP(1)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(req_a[5]), .Up(req_a[0]), .Jmp(req_a[2]),
    .Br(req_a[1]), .Call(req_a[3]), .Ret(req_a[4]), .Target(target), .Offset(offset),
    .Addr(a_addr), .Halted(a_halted), .StackFull(a_full), .StackEmpty(a_empty),
    .Fault(a_fault)
  );

  pc_branch_stack #(.N(7), .DEPTH(4), .WRAP(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(req_b[5]), .Up(req_b[0]), .Jmp(req_b[2]),
    .Br(req_b[1]), .Call(req_b[3]), .Ret(req_b[4]), .Target(target), .Offset(offset),
    .Addr(b_addr), .Halted(b_halted), .StackFull(b_full), .StackEmpty(b_empty),
    .Fault(b_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req_v);
    end
  endtask

  task automatic step(input logic [5:0] r, input logic [6:0] t, input logic [6:0] o,
                      input logic [6:0] ea, input logic eh, input logic ef,
                      input logic efull, input logic eempty, input string nm);
    exp_t e;
    @(negedge Clk);
    req = r; target = t; offset = o;
    @(posedge Clk);
    e.dut = sel; e.addr = ea; e.halted = eh; e.fault = ef; e.full = efull; e.empty = eempty;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor: one queued expectation per update edge
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      if (mon_e.dut == 1'b0) begin
        chk({mon_nm, ".addr"},   32'(a_addr),   32'(mon_e.addr));
        chk({mon_nm, ".halted"}, 32'(a_halted), 32'(mon_e.halted));
        chk({mon_nm, ".fault"},  32'(a_fault),  32'(mon_e.fault));
        chk({mon_nm, ".full"},   32'(a_full),   32'(mon_e.full));
        chk({mon_nm, ".empty"},  32'(a_empty),  32'(mon_e.empty));
      end else begin
        chk({mon_nm, ".addr"},   32'(b_addr),   32'(mon_e.addr));
        chk({mon_nm, ".halted"}, 32'(b_halted), 32'(mon_e.halted));
        chk({mon_nm, ".fault"},  32'(b_fault),  32'(mon_e.fault));
        chk({mon_nm, ".full"},   32'(b_full),   32'(mon_e.full));
        chk({mon_nm, ".empty"},  32'(b_empty),  32'(mon_e.empty));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; sel = 1'b0; req = R_NONE; target = 7'd0; offset = 7'd0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // WRAP=1 instance
    step(R_NONE, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    for (int i = 1; i <= 130; i++)
      step(R_UP, 7'd0, 7'd0, 7'(i), 1'b0, 1'b0, 1'b0, 1'b1, "up_wrap");
    step(R_BR,  7'd0,  7'h7D, 7'd127, 1'b0, 1'b0, 1'b0, 1'b1, "br_wrap_low");
    step(R_JMP, 7'd20, 7'd0,  7'd20,  1'b0, 1'b0, 1'b0, 1'b1, "jmp20");
    step(R_BR,  7'd0,  7'h7D, 7'd17,  1'b0, 1'b0, 1'b0, 1'b1, "br_minus3");
    step(R_JMP, 7'd5,  7'd0,  7'd5,   1'b0, 1'b0, 1'b0, 1'b1, "jmp5");
    step(R_CALL, 7'd40,  7'd0, 7'd40, 1'b0, 1'b0, 1'b0, 1'b0, "call40");
    step(R_CALL, 7'd60,  7'd0, 7'd60, 1'b0, 1'b0, 1'b0, 1'b0, "call60");
    step(R_CALL, 7'd80,  7'd0, 7'd80, 1'b0, 1'b0, 1'b0, 1'b0, "call80");
    step(R_CALL, 7'd90,  7'd0, 7'd90, 1'b0, 1'b0, 1'b1, 1'b0, "call90_full");
    step(R_CALL, 7'd100, 7'd0, 7'd90, 1'b0, 1'b1, 1'b1, 1'b0, "call_overflow");
    step(R_RET, 7'd0, 7'd0, 7'd81, 1'b0, 1'b1, 1'b0, 1'b0, "ret81");
    step(R_RET, 7'd0, 7'd0, 7'd61, 1'b0, 1'b1, 1'b0, 1'b0, "ret61");
    step(R_RET, 7'd0, 7'd0, 7'd41, 1'b0, 1'b1, 1'b0, 1'b0, "ret41");
    step(R_RET, 7'd0, 7'd0, 7'd6,  1'b0, 1'b1, 1'b0, 1'b1, "ret6_empty");
    step(R_RET, 7'd0, 7'd0, 7'd6,  1'b0, 1'b1, 1'b0, 1'b1, "ret_underflow");
    step(R_JMP | R_BR | R_UP, 7'd50, 7'd5, 7'd50, 1'b0, 1'b1, 1'b0, 1'b1, "jmp_over_br");
    step(R_BR | R_UP, 7'd0, 7'd3, 7'd53, 1'b0, 1'b1, 1'b0, 1'b1, "br_over_up");
    step(R_CLR, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "clr");
    step(R_JMP,  7'd32, 7'd0, 7'd32, 1'b0, 1'b0, 1'b0, 1'b1, "jmp32");
    step(R_CALL, 7'd70, 7'd0, 7'd70, 1'b0, 1'b0, 1'b0, 1'b0, "call70");
    step(R_RET | R_CALL | R_UP, 7'd99, 7'd0, 7'd33, 1'b0, 1'b0, 1'b0, 1'b1, "ret_priority");
    step(R_JMP, 7'd45, 7'd0, 7'd45, 1'b0, 1'b0, 1'b0, 1'b1, "jmp45");
    step(R_CLR | R_CALL, 7'd99, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "clr_priority");
    step(R_RET, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, "clr_no_push");
    step(R_JMP,  7'd127, 7'd0, 7'd127, 1'b0, 1'b1, 1'b0, 1'b1, "jmp127");
    step(R_CALL, 7'd10,  7'd0, 7'd10,  1'b0, 1'b1, 1'b0, 1'b0, "call_at_top");
    step(R_RET,  7'd0,   7'd0, 7'd0,   1'b0, 1'b1, 1'b0, 1'b1, "ret_wrapped_push");
    step(R_JMP,  7'd20, 7'd0, 7'd20, 1'b0, 1'b1, 1'b0, 1'b1, "pre_jmp20");
    step(R_CALL, 7'd30, 7'd0, 7'd30, 1'b0, 1'b1, 1'b0, 1'b0, "pre_call30");
    step(R_CALL, 7'd50, 7'd0, 7'd50, 1'b0, 1'b1, 1'b0, 1'b0, "pre_call50");

    // asynchronous reset in the middle of a cycle
    @(negedge Clk);
    req = R_NONE;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async.addr",   32'(a_addr),   32'd0);
    chk("async.halted", 32'(a_halted), 32'd0);
    chk("async.fault",  32'(a_fault),  32'd0);
    chk("async.full",   32'(a_full),   32'd0);
    chk("async.empty",  32'(a_empty),  32'd1);
    #1 Reset_n = 1'b1;

    // WRAP=0 instance
    sel = 1'b1;
    step(R_NONE, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, "b_reset");
    for (int i = 1; i <= 127; i++)
      step(R_UP, 7'd0, 7'd0, 7'(i), 1'b0, 1'b0, 1'b0, 1'b1, "b_up");
    step(R_UP,  7'd0,  7'd0,  7'd127, 1'b1, 1'b0, 1'b0, 1'b1, "b_halt");
    step(R_UP,  7'd0,  7'd0,  7'd127, 1'b1, 1'b0, 1'b0, 1'b1, "b_halt_hold");
    step(R_BR,  7'd0,  7'h7B, 7'd127, 1'b1, 1'b0, 1'b0, 1'b1, "b_br_ignored");
    step(R_JMP, 7'd10, 7'd0,  7'd10,  1'b0, 1'b0, 1'b0, 1'b1, "b_jmp_release");
    step(R_UP,  7'd0,  7'd0,  7'd11,  1'b0, 1'b0, 1'b0, 1'b1, "b_up_resume");

    @(negedge Clk);
    req = R_NONE;
    repeat (2) @(negedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_stack.md
# pc_branch_stack

Parametrised program counter for the programmable processor. It supersedes the fixed 7-bit wrap-only counter and adds:
- absolute jump and PC-relative branch
- a small call/return address stack
- a selectable end-of-memory policy: wrap or halt

It drives the instruction-memory address and is steered by the controller FSM.

## Interface
Parameters:
- N, 7, address width; memory spans 0 .. 2^N-1
- DEPTH, 4, return-stack entries (≥1)
- WRAP, 1, 1 = increment past 2^N-1 wraps to 0; 0 = hold at 2^N-1 and assert Halted

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Clr  in  1  synchronous clear; same effect as reset
- Up  in  1  increment enable
- Jmp  in  1  absolute jump to Target
- Br  in  1  relative branch by Offset
- Call  in  1  push return address, jump to Target
- Ret  in  1  pop return address into Addr
- Target  in  N  absolute destination
- Offset  in  N  signed two's-complement branch displacement
- Addr  out  N  current PC, registered
- Halted  out  1  registered; end-of-memory reached with WRAP=0
- StackFull  out  1  combinational; stack count == DEPTH
- StackEmpty  out  1  combinational; stack count == 0
- Fault  out  1  registered, sticky; stack overflow or underflow occurred

## Operation
- Reset (Reset_n=0, asynchronous) and Clr=1 (synchronous) both force: Addr=0, stack count=0, Halted=0, Fault=0. Stack entry contents are don't-care after either.
- Exactly one action per cycle. Priority is Clr > Ret > Call > Jmp > Br > Up; lower-priority requests in the same cycle are ignored.
- Ret:
  - Stack non-empty: Addr ← top entry; count−1.
  - Stack empty: Addr holds; Fault ← 1.
- Call:
  - Stack not full: push (Addr+1) mod 2^N; Addr ← Target; count+1.
  - Stack full: no push; Addr holds; Fault ← 1.
- Jmp: Addr ← Target.
- Br: Addr ← (Addr + sign-extended Offset) mod 2^N; always wraps, regardless of WRAP.
- Up:
  - Addr < 2^N-1: Addr+1.
  - Addr = 2^N-1 and WRAP=1: Addr ← 0.
  - Addr = 2^N-1 and WRAP=0: Addr holds; Halted ← 1.
- While Halted=1, Up and Br are ignored. Jmp, Call, Ret and Clr are honoured, and any of them that actually changes Addr clears Halted.
- No request: all state holds.
- Fault is cleared only by reset or Clr.

## Timing
- Addr, Halted and Fault update one edge after the request is sampled. Zero-bubble: a new request is accepted every cycle.
- StackFull and StackEmpty reflect the count register with no extra latency; they are valid in the same cycle Call or Ret is presented.
- Back-to-back Call then Ret: the Ret in cycle k+1 sees the entry pushed at edge k.
- Reset_n assertion mid-operation clears state immediately, without waiting for Clk. Deassertion is assumed synchronised upstream.
- Push address arithmetic is N-bit modular: a Call at Addr=2^N-1 pushes 0.

## Structure
- Package pc_pkg holds:
  - typedef enum pc_act_t {ACT_NONE, ACT_CLR, ACT_RET, ACT_CALL, ACT_JMP, ACT_BR, ACT_UP}, the priority-resolved action
  - localparam CNT_W = $clog2(DEPTH+1)
- Sub-module ret_stack (LIFO):
  - parameters N, DEPTH
  - push/pop strobes, push data, top data, full/empty
  - synchronous push/pop, asynchronous active-low reset of the count only
- Top level contains:
  - priority resolver, combinational, produces pc_act_t
  - next-Addr mux
  - Halted and Fault registers

## Test plan
- Defaults (N=7, WRAP=1): reset, then Up held 130 cycles → Addr runs 0..127, 0, 1; Halted stays 0.
- WRAP=0: Up from reset → Addr reaches 127 and holds; Halted=1 from that edge. Br Offset=−5 is ignored. Jmp Target=10 → Addr=10, Halted=0.
- Addr=20: Br Offset=0x7D (−3) → Addr=17. From Addr=2, Br −3 → Addr=127 (wraps).
- Nested calls:
  - Call 40 at Addr=5, Call 60, Call 80, Call 90 → StackFull=1.
  - Fifth Call → Addr stays 90, Fault=1.
  - Four Rets → Addr 81, 61, 41, 6; StackEmpty=1.
  - Further Ret → Addr holds, Fault stays 1.
- Simultaneous Ret+Call+Up with one stacked entry 33 → Addr=33, count 0. Clr+Call → Addr=0, nothing pushed.
- Reset_n pulsed low mid-cycle with Addr=50, count=2, Fault=1 → all outputs 0 before the next Clk edge; StackEmpty=1.
